// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display.
// Hex glyph table, source-select encodings and blank levels.
package seg_pkg;

    typedef enum logic [1:0] {
        SEL_LED    = 2'd0,
        SEL_ALL    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JMP    = 2'd3
    } sel_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low g..a patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment glyph (g..a).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg7
);

    always_comb begin
        seg7 = HEX_SEG[nib];
    end

endmodule

// File: rtl/seg_scan_display.sv
// 8-digit multiplexed hex display with per-frame snapshot.
// Define SEG_BLANK_EN to blank leading zero digits.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [1:0]  sel,
    input  logic [31:0] leddata,
    input  logic [31:0] count_all,
    input  logic [31:0] count_branch,
    input  logic [31:0] count_jmp,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    logic [DIV_WIDTH-1:0] pre_q, pre_d;
    logic [2:0]           idx_q, idx_d;
    logic [31:0]          snap_q, snap_d;
    logic [1:0]           snap_sel_q, snap_sel_d;
    logic [7:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frame_tick_q, frame_tick_d;

    logic        tick;
    logic        load;
    logic [31:0] src;
    logic [3:0]  nib;
    logic [6:0]  seg7;
    logic        blank;
    logic        dp_n;

    always_comb begin
        src = leddata;
        unique case (sel_e'(sel))
            SEL_LED:    src = leddata;
            SEL_ALL:    src = count_all;
            SEL_BRANCH: src = count_branch;
            SEL_JMP:    src = count_jmp;
        endcase
    end

    always_comb begin
        tick       = &pre_q;
        load       = tick && (idx_q == 3'd7);
        pre_d      = pre_q + DIV_WIDTH'(1);
        idx_d      = tick ? idx_q + 3'd1 : idx_q;
        snap_d     = load ? src : snap_q;
        snap_sel_d = load ? sel : snap_sel_q;
    end

    // Outputs are built from the next-state index and snapshot so the
    // first digit of a new frame already shows the fresh value.
    always_comb begin
        nib = snap_d[{idx_d, 2'b00} +: 4];
`ifdef SEG_BLANK_EN
        blank = (idx_d != 3'd0)
             && ((snap_d >> {idx_d, 2'b00}) == 32'd0);
`else
        blank = 1'b0;
`endif
        dp_n = !((idx_d == 3'd7) && (snap_sel_d != SEL_LED));
    end

    seg_hex_decode u_dec (
        .nib  (nib),
        .seg7 (seg7)
    );

    always_comb begin
        an_d         = an_q;
        seg_d        = seg_q;
        frame_tick_d = load;
        if (tick) begin
            an_d  = ~(8'd1 << idx_d);
            seg_d = {dp_n, blank ? 7'h7F : seg7};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_q        <= '0;
            idx_q        <= 3'd7;
            snap_q       <= '0;
            snap_sel_q   <= SEL_LED;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_sel_q   <= snap_sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIV_WIDTH=2.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  sel;
    logic [31:0] leddata;
    logic [31:0] count_all;
    logic [31:0] count_branch;
    logic [31:0] count_jmp;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_scan_display #(.DIV_WIDTH(2)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .sel          (sel),
        .leddata      (leddata),
        .count_all    (count_all),
        .count_branch (count_branch),
        .count_jmp    (count_jmp),
        .an           (an),
        .seg          (seg),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [31:0] v,
                                           input int d,
                                           input logic dp_on);
        logic [7:0] t;
        t[7]   = !(d == 7 && dp_on);
        t[6:0] = hex_tab[v[d*4 +: 4]];
`ifdef SEG_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) t[6:0] = 7'h7F;
`endif
        return t;
    endfunction

    task automatic show(input int d, input logic [31:0] v,
                        input logic dp_on);
        logic [7:0] ea;
        ea = ~(8'd1 << d);
        chk($sformatf("an_d%0d", d), an, ea);
        chk($sformatf("seg_d%0d_%h", d, v), seg, exp_seg(v, d, dp_on));
        chk($sformatf("ft_d%0d", d), frame_tick, logic'(d == 0));
    endtask

    task automatic adv();
        @(posedge clk); #1;
        chk("ft_low", frame_tick, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n        = 1'b0;
        sel          = 2'd0;
        leddata      = 32'h1234_ABCD;
        count_all    = 32'd0;
        count_branch = 32'd0;
        count_jmp    = 32'd0;
        #12;
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ft", frame_tick, 1'b0);

        @(negedge clk) clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("dark_an", an, 8'hFF);
        chk("dark_seg", seg, 8'hFF);
        @(posedge clk); #1;

        // frame 1; leddata changes while digit 3 is lit
        for (int d = 0; d < 8; d++) begin
            if (d > 0) adv();
            show(d, 32'h1234_ABCD, 1'b0);
            if (d == 3) leddata = 32'h0000_0005;
        end

        adv();
        for (int d = 0; d < 8; d++) begin
            if (d > 0) adv();
            show(d, 32'h0000_0005, 1'b0);
            if (d == 4) begin
                sel          = 2'd2;
                count_branch = 32'hFFFF_FFFF;
            end
        end

        adv();
        for (int d = 0; d < 8; d++) begin
            if (d > 0) adv();
            show(d, 32'hFFFF_FFFF, 1'b1);
            if (d == 2) begin
                sel       = 2'd1;
                count_all = 32'h89AB_CDEF;
                count_jmp = 32'h0F0F_1234;
            end
        end

        adv();
        for (int d = 0; d < 8; d++) begin
            if (d > 0) adv();
            show(d, 32'h89AB_CDEF, 1'b1);
        end

        // switch sel inside the idx==7 tick cycle itself
        repeat (3) @(posedge clk);
        #1;
        sel = 2'd3;
        @(posedge clk); #1;
        for (int d = 0; d < 6; d++) begin
            if (d > 0) adv();
            show(d, 32'h0F0F_1234, 1'b1);
        end

        // asynchronous reset while digit 5 is lit
        #2 clr_n = 1'b0;
        #1;
        chk("midrst_an", an, 8'hFF);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_ft", frame_tick, 1'b0);
        sel     = 2'd0;
        leddata = 32'd0;
        @(negedge clk) clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_dark_an", an, 8'hFF);
        @(posedge clk); #1;

        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 8; d++) begin
                if (f > 0 || d > 0) adv();
                show(d, 32'd0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
